// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: mode encodings and per-bit next-value selection for the universal shift register
package univ_shift_reg_pkg;
  localparam int MODE_W = 3;
  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'd6;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'd7;

  // Neighbour taps are resolved by the caller, so edge bits and WIDTH=1 need no special cases here.
  function automatic logic next_bit(input logic [MODE_W-1:0] mode, input logic cur, ld, shl, shr, rol, ror, asr);
    case (mode)
      MODE_HOLD: next_bit = cur;
      MODE_LOAD: next_bit = ld;
      MODE_SHL:  next_bit = shl;
      MODE_SHR:  next_bit = shr;
      MODE_ROL:  next_bit = rol;
      MODE_ROR:  next_bit = ror;
      MODE_ASR:  next_bit = asr;
      default:   next_bit = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control, data and output bundle of the universal shift register
interface univ_shift_reg_if
  import univ_shift_reg_pkg::*;
#(parameter int WIDTH = 8);
  logic              en;
  logic [MODE_W-1:0] mode;
  logic [WIDTH-1:0]  d;
  logic              sin_l;
  logic              sin_r;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  q_bar;
  logic              so_msb;
  logic              so_lsb;
  modport master (output en, mode, d, sin_l, sin_r, input q, q_bar, so_msb, so_lsb);
  modport slave  (input en, mode, d, sin_l, sin_r, output q, q_bar, so_msb, so_lsb);
endinterface

// File: rtl/univ_shift_reg_d_ff_en.sv
// d_ff_en: one-bit enabled D flip-flop with asynchronous active-low reset to rst_val
module d_ff_en (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic rst_val,
  input  logic d,
  output logic q,
  output logic q_bar
);
  logic q_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) q_q <= rst_val;
    else if (en) q_q <= d;
  assign q     = q_q;
  assign q_bar = ~q_q;
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: mode-selected hold/load/shift/rotate/asr/clear register built from d_ff_en slices
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input logic clk,
  input logic rst,
  univ_shift_reg_if.slave bus
);
  logic [WIDTH-1:0] q_q, qb, nxt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic lo_shl, lo_rol, hi_shr, hi_ror, hi_asr;
    if (i == 0) begin : g_lsb
      assign lo_shl = bus.sin_l;
      assign lo_rol = q_q[WIDTH-1];
    end else begin : g_lo
      assign lo_shl = q_q[i-1];
      assign lo_rol = q_q[i-1];
    end
    // Top slice: SHR takes sin_r, ROR wraps bit 0, ASR keeps the sign (WIDTH=1 thus holds on ROR/ASR).
    if (i == WIDTH-1) begin : g_msb
      assign hi_shr = bus.sin_r;
      assign hi_ror = q_q[0];
      assign hi_asr = q_q[i];
    end else begin : g_hi
      assign hi_shr = q_q[i+1];
      assign hi_ror = q_q[i+1];
      assign hi_asr = q_q[i+1];
    end
    assign nxt_d[i] = next_bit(bus.mode, q_q[i], bus.d[i], lo_shl, hi_shr, lo_rol, hi_ror, hi_asr);
    d_ff_en u_ff (
      .clk(clk), .rst(rst), .en(bus.en), .rst_val(RESET_VALUE[i]),
      .d(nxt_d[i]), .q(q_q[i]), .q_bar(qb[i])
    );
  end

  assign bus.q      = q_q;
  assign bus.q_bar  = qb;
  assign bus.so_msb = q_q[WIDTH-1];
  assign bus.so_lsb = q_q[0];
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed vectors with hand-computed results for univ_shift_reg (WIDTH=8, reset 8'hA5)
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  univ_shift_reg_if #(.WIDTH(8)) bus ();
  univ_shift_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [MODE_W-1:0] m, input logic [7:0] dv, input logic sl, input logic sr);
    bus.en = e; bus.mode = m; bus.d = dv; bus.sin_l = sl; bus.sin_r = sr;
  endtask

  task automatic load(input logic [7:0] v);
    drive(1'b1, MODE_LOAD, v, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    logic [7:0] bits;
    rst = 1'b1;
    drive(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("rst_q", bus.q, 8'hA5);
    chk("rst_qbar", bus.q_bar, 8'h5A);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_hold_q", bus.q, 8'hA5);
      chk("rst_hold_qbar", bus.q_bar, 8'h5A);
    end
    rst = 1'b1;
    step();
    chk("rst_release", bus.q, 8'hFF);

    load(8'h3C);
    chk("load", bus.q, 8'h3C);
    chk("load_qbar", bus.q_bar, 8'hC3);
    drive(1'b0, MODE_LOAD, 8'h00, 1'b0, 1'b0);
    step();
    chk("en0_a", bus.q, 8'h3C);
    step();
    chk("en0_b", bus.q, 8'h3C);
    drive(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0);
    step();
    chk("hold", bus.q, 8'h3C);

    load(8'h81);
    drive(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
    chk("so_msb", {7'd0, bus.so_msb}, 8'h01);
    step();
    chk("shl", bus.q, 8'h02);
    load(8'h81);
    drive(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
    chk("so_lsb", {7'd0, bus.so_lsb}, 8'h01);
    step();
    chk("shr", bus.q, 8'hC0);

    load(8'h00);
    bits = 8'b10110010;
    for (int b = 7; b >= 0; b--) begin
      drive(1'b1, MODE_SHL, 8'h00, bits[b], 1'b0);
      step();
    end
    chk("serial_in", bus.q, 8'hB2);

    load(8'h81);
    drive(1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0);
    step();
    chk("rol", bus.q, 8'h03);
    load(8'h81);
    drive(1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0);
    step();
    chk("ror", bus.q, 8'hC0);
    load(8'h90);
    drive(1'b1, MODE_ASR, 8'h00, 1'b0, 1'b0);
    step();
    chk("asr1", bus.q, 8'hC8);
    step();
    chk("asr2", bus.q, 8'hE4);

    load(8'h7E);
    drive(1'b1, MODE_CLR, 8'h00, 1'b0, 1'b0);
    step();
    chk("clr", bus.q, 8'h00);
    load(8'h5A);
    drive(1'b0, MODE_CLR, 8'h00, 1'b0, 1'b0);
    step();
    chk("clr_en0", bus.q, 8'h5A);

    load(8'h01);
    drive(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
    step();
    chk("shl_seq", bus.q, 8'h02);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_q", bus.q, 8'hA5);
    chk("mid_rst_qbar", bus.q_bar, 8'h5A);
    #1 rst = 1'b1;
    drive(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
    step();
    chk("shl_resume", bus.q, 8'h4B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register built from per-bit D flip-flop slices, each slice with enable and asynchronous reset. One 3-bit mode input selects hold, parallel load, logical shifts, rotates, arithmetic shift or clear. Both true and complemented outputs are provided. It sits wherever the design needs a configurable data register, serial/parallel converter or shifter stage.

## Interface
- WIDTH, 8: register width in bits; must be ≥1.
- RESET_VALUE, {WIDTH{1'b0}}: value of q while rst is asserted.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  update enable; 0 holds the register regardless of mode.
- mode  input  3  operation select; encodings are listed under Operation.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input shifted into bit 0 on SHL.
- sin_r  input  1  serial input shifted into bit WIDTH-1 on SHR.
- q  output  WIDTH  register state.
- q_bar  output  WIDTH  always ~q.
- so_msb  output  1  q[WIDTH-1], the bit shifted out by SHL.
- so_lsb  output  1  q[0], the bit shifted out by SHR.

## Operation
- Modes, applied at the rising edge of clk when en=1 and rst=1:
  - 3'd0 HOLD: q unchanged.
  - 3'd1 LOAD: q ← d.
  - 3'd2 SHL: q ← {q[WIDTH-2:0], sin_l}.
  - 3'd3 SHR: q ← {sin_r, q[WIDTH-1:1]}.
  - 3'd4 ROL: q ← {q[WIDTH-2:0], q[WIDTH-1]}.
  - 3'd5 ROR: q ← {q[0], q[WIDTH-1:1]}.
  - 3'd6 ASR: q ← {q[WIDTH-1], q[WIDTH-1:1]}, so the sign bit is replicated.
  - 3'd7 CLR: q ← 0. This is a synchronous clear. It does not load RESET_VALUE.
- en=0: q holds for every mode, including CLR.
- WIDTH=1 degenerate case:
  - SHL gives q←sin_l.
  - SHR gives q←sin_r.
  - ROL, ROR and ASR hold.
- All 8 encodings are defined. There is no illegal mode.
- Next-state selection is purely combinational. q is the only state.

## Timing
- Reset:
  - Assertion (rst=0) forces q=RESET_VALUE and q_bar=~RESET_VALUE immediately, without waiting for a clock edge.
  - While rst is asserted, the register ignores en, mode and d.
  - The first rising edge with rst=1 performs the selected operation normally.
- Reset asserted mid-operation overrides any in-progress shift sequence. No partial update is retained.
- Latency is 1 cycle: inputs sampled at edge N appear on q after edge N.
- q_bar, so_msb and so_lsb are combinational from q, so they update in the same cycle as q.
- No glitch-free requirement on q_bar beyond zero-delay RTL equivalence.
- Inputs must be stable around the rising edge. There is no internal synchroniser.

## Structure
- Package univ_shift_reg_pkg holds:
  - The mode localparams MODE_HOLD … MODE_CLR with their 3-bit encodings.
  - MODE_W = 3.
- Sub-module d_ff_en is one bit-slice flip-flop:
  - Ports: clk, rst (active-low, async), en, rst_val, d, q, q_bar.
  - It is instantiated WIDTH times by a generate loop.
  - Slice i's rst_val is RESET_VALUE[i].
- The top level holds only:
  - The per-bit next-value mux driven by mode.
  - The serial-out assignments.

## Test plan
All scenarios use WIDTH=8 and RESET_VALUE=8'hA5.
- Reset: rst=0 at time 0, toggle clk for 3 cycles with en=1 and mode=LOAD, d=8'hFF → q=8'hA5 and q_bar=8'h5A throughout. Release rst: the next edge gives q=8'hFF.
- Load/hold/enable: LOAD 8'h3C → q=8'h3C. Then mode=LOAD, d=8'h00, en=0 for 2 edges → q stays 8'h3C. Then mode=HOLD, en=1 → q stays 8'h3C.
- Shifts:
  - From 8'h81, SHL with sin_l=0 → 8'h02, and so_msb=1 before the edge.
  - From 8'h81, SHR with sin_r=1 → 8'hC0.
  - Serially clock in 8 bits 1,0,1,1,0,0,1,0 via SHL → q=8'hB2.
- Rotates/arith:
  - From 8'h81, ROL → 8'h03.
  - From 8'h81, ROR → 8'hC0.
  - 8'h90 ASR twice → 8'hC8, then 8'hE4.
- Clear vs reset:
  - From 8'h7E, CLR → 8'h00, not 8'hA5.
  - With en=0, CLR → q unchanged.
  - Assert rst mid-way through an SHL sequence, between edges → q=8'hA5 immediately. After release, SHL resumes from 8'hA5.
